// File: rtl/imem_ctrl_if.sv
// Bundle of the fetch, loader and memory-port signals around imem_ctrl.
// slave is the controller's view; master is the requesters/memory side.
interface imem_ctrl_if #(
    parameter int DEPTH_W = 6
);
    logic               f_req_valid;
    logic               f_req_ready;
    logic [31:0]        f_addr;
    logic               f_rsp_valid;
    logic               f_rsp_ready;
    logic [31:0]        f_rdata;
    logic               f_err;

    logic               l_req_valid;
    logic               l_req_ready;
    logic               l_we;
    logic [31:0]        l_addr;
    logic [31:0]        l_wdata;
    logic               l_rsp_valid;
    logic               l_rsp_ready;
    logic [31:0]        l_rdata;
    logic               l_err;

    logic [DEPTH_W-1:0] mem_addr;
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    modport slave (
        input  f_req_valid, f_addr, f_rsp_ready,
        input  l_req_valid, l_we, l_addr, l_wdata, l_rsp_ready,
        input  mem_rdata,
        output f_req_ready, f_rsp_valid, f_rdata, f_err,
        output l_req_ready, l_rsp_valid, l_rdata, l_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req_valid, f_addr, f_rsp_ready,
        output l_req_valid, l_we, l_addr, l_wdata, l_rsp_ready,
        output mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rdata, f_err,
        input  l_req_ready, l_rsp_valid, l_rdata, l_err,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory arbiter: fetch and loader share one memory port, round-robin on ties.
// Optional misaligned-access rejection is enabled with macro IMEM_CTRL_ALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | arbitrate requesters, accept one
// ACCESS | drive memory port from captured request, latch read data
// RESP   | hold response to the granted requester until it is taken
module imem_ctrl #(
    parameter int DEPTH_W = 6
) (
    input logic         clk,
    input logic         reset,
    imem_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic SRC_F = 1'b0;
    localparam logic SRC_L = 1'b1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               last_grant;
    logic               owner;
    logic [DEPTH_W-1:0] cap_idx;
    logic               cap_we;
    logic [31:0]        cap_wdata;
    logic               cap_bad;
    logic [31:0]        rsp_data;
    logic               rsp_err;

    logic               grant_f;
    logic               grant_l;
    logic               accept;
    logic [31:0]        req_addr;
    logic               misaligned;
    logic               rsp_taken;

    // On a tie the requester that did not win last time is served.
    assign grant_f = (state == IDLE) && bus.f_req_valid &&
                     (!bus.l_req_valid || (last_grant == SRC_L));
    assign grant_l = (state == IDLE) && bus.l_req_valid &&
                     (!bus.f_req_valid || (last_grant == SRC_F));
    assign accept  = grant_f || grant_l;

    assign bus.f_req_ready = grant_f;
    assign bus.l_req_ready = grant_l;

    assign req_addr  = grant_l ? bus.l_addr : bus.f_addr;
    assign rsp_taken = (owner == SRC_L) ? bus.l_rsp_ready : bus.f_rsp_ready;

`ifdef IMEM_CTRL_ALIGN_CHK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
    logic unused_bits;
    assign unused_bits = ^{req_addr[31:DEPTH_W+2]};
`else
    assign misaligned = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{req_addr[31:DEPTH_W+2], req_addr[1:0], rsp_err};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_taken) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SRC_L;
            owner      <= SRC_F;
            cap_idx    <= '0;
            cap_we     <= 1'b0;
            cap_wdata  <= '0;
            cap_bad    <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_l ? SRC_L : SRC_F;
                owner      <= grant_l ? SRC_L : SRC_F;
                cap_idx    <= req_addr[DEPTH_W+1:2];
                cap_we     <= grant_l && bus.l_we;
                cap_wdata  <= grant_l ? bus.l_wdata : 32'h0;
                cap_bad    <= misaligned;
            end
            if (state == ACCESS) begin
                rsp_data <= (cap_we || cap_bad) ? 32'h0 : bus.mem_rdata;
                rsp_err  <= cap_bad;
            end
        end
    end

    // A rejected write never reaches the array.
    assign bus.mem_addr  = cap_idx;
    assign bus.mem_we    = (state == ACCESS) && cap_we && !cap_bad;
    assign bus.mem_wdata = cap_wdata;

    assign bus.f_rsp_valid = (state == RESP) && (owner == SRC_F);
    assign bus.l_rsp_valid = (state == RESP) && (owner == SRC_L);
    assign bus.f_rdata     = rsp_data;
    assign bus.l_rdata     = rsp_data;

`ifdef IMEM_CTRL_ALIGN_CHK_EN
    assign bus.f_err = rsp_err;
    assign bus.l_err = rsp_err;
`else
    assign bus.f_err = 1'b0;
    assign bus.l_err = 1'b0;
`endif
endmodule
